// File: rtl/reg_file_mr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_mr_pkg : shared sizing helpers and defaults for reg_file_mr |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+

`ifndef RF_SLICE
`define RF_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package reg_file_mr_pkg;

   localparam int RF_DEF_WIDTH = 16;
   localparam int RF_DEF_DEPTH = 8;

   function automatic int rf_clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_mr_rf_read_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_read_port : one registered read port with range check and bypass  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+

module rf_read_port
   import reg_file_mr_pkg::*;
#(
   parameter int WIDTH   = RF_DEF_WIDTH,
   parameter int DEPTH   = RF_DEF_DEPTH,
   parameter int AW      = rf_clog2(RF_DEF_DEPTH),
   parameter int BYPASS  = 1,
   parameter int ZERO_R0 = 0
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   re,
   input  logic [AW-1:0]          raddr,
   input  logic                   wr_en,
   input  logic [AW-1:0]          waddr,
   input  logic [WIDTH-1:0]       wdata,
   input  logic [DEPTH*WIDTH-1:0] regs,
   output logic [WIDTH-1:0]       rdata,
   output logic                   rvalid
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic             addr_ok;
   logic [WIDTH-1:0] sel;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] rdata_d, rdata_q;
   logic             rvalid_d, rvalid_q;

   always_comb begin
      addr_ok = ({1'b0, raddr} < DEPTH_C);
      sel     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (raddr == AW'(k)) begin
            sel = `RF_SLICE(regs, k, WIDTH);
         end
      end
      // wr_en already excludes out-of-range and masked-r0 writes, so a hit is always writable
      if (!addr_ok || ((ZERO_R0 != 0) && (raddr == '0))) begin
         result = '0;
      end else if ((BYPASS != 0) && wr_en && (waddr == raddr)) begin
         result = wdata;
      end else begin
         result = sel;
      end
      rdata_d  = re ? result : rdata_q;
      rvalid_d = re;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;

endmodule

`default_nettype wire

// File: rtl/reg_file_mr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_mr : multi-read-port register file with debug Q bus         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+

module reg_file_mr
   import reg_file_mr_pkg::*;
#(
   parameter int WIDTH   = RF_DEF_WIDTH,
   parameter int DEPTH   = RF_DEF_DEPTH,
   parameter int NREAD   = 2,
   parameter int BYPASS  = 1,
   parameter int ZERO_R0 = 0,
   localparam int AW     = rf_clog2(DEPTH)
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we,
   input  logic [AW-1:0]          waddr,
   input  logic [WIDTH-1:0]       wdata,
   input  logic [NREAD-1:0]       re,
   input  logic [NREAD*AW-1:0]    raddr,
   output logic [NREAD*WIDTH-1:0] rdata,
   output logic [NREAD-1:0]       rvalid,
   output logic [DEPTH*WIDTH-1:0] q
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0]       regs_q [DEPTH];
   logic [WIDTH-1:0]       regs_d [DEPTH];
   logic [DEPTH*WIDTH-1:0] regs_flat;
   logic                   wr_en;

   always_comb begin
      wr_en = we && ({1'b0, waddr} < DEPTH_C) && !((ZERO_R0 != 0) && (waddr == '0));
      for (int k = 0; k < DEPTH; k++) begin
         regs_d[k] = regs_q[k];
         if (wr_en && (waddr == AW'(k))) begin
            regs_d[k] = wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) begin
         if (rst) begin
            regs_q[k] <= '0;
         end else begin
            regs_q[k] <= regs_d[k];
         end
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_flat
      assign `RF_SLICE(regs_flat, k, WIDTH) = regs_q[k];
      assign `RF_SLICE(q, k, WIDTH) = ((ZERO_R0 != 0) && (k == 0)) ? '0 : regs_q[k];
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      rf_read_port #(
         .WIDTH   (WIDTH),
         .DEPTH   (DEPTH),
         .AW      (AW),
         .BYPASS  (BYPASS),
         .ZERO_R0 (ZERO_R0)
      ) u_port (
         .clk    (clk),
         .rst    (rst),
         .re     (re[i]),
         .raddr  (`RF_SLICE(raddr, i, AW)),
         .wr_en  (wr_en),
         .waddr  (waddr),
         .wdata  (wdata),
         .regs   (regs_flat),
         .rdata  (`RF_SLICE(rdata, i, WIDTH)),
         .rvalid (rvalid[i])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reg_file_mr : directed checks over five reg_file_mr configurations|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+

module tb_reg_file_mr;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [2:0]  waddr;
   logic [31:0] wdata;
   logic [2:0]  re;
   logic [8:0]  raddr;

   logic [31:0]  rd_def, rd_nb, rd_z, rd_d6;
   logic [1:0]   rv_def, rv_nb, rv_z, rv_d6;
   logic [127:0] q_def, q_nb, q_z;
   logic [95:0]  q_d6;
   logic [95:0]  rd_n3;
   logic [2:0]   rv_n3;
   logic [255:0] q_n3;

   int checks = 0;
   int errors = 0;
   logic [127:0] exp_q;

   always #5 clk = ~clk;

   reg_file_mr #(.WIDTH(16), .DEPTH(8), .NREAD(2), .BYPASS(1), .ZERO_R0(0)) u_def (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata[15:0]),
      .re(re[1:0]), .raddr(raddr[5:0]), .rdata(rd_def), .rvalid(rv_def), .q(q_def));
   reg_file_mr #(.WIDTH(16), .DEPTH(8), .NREAD(2), .BYPASS(0), .ZERO_R0(0)) u_nb (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata[15:0]),
      .re(re[1:0]), .raddr(raddr[5:0]), .rdata(rd_nb), .rvalid(rv_nb), .q(q_nb));
   reg_file_mr #(.WIDTH(16), .DEPTH(8), .NREAD(2), .BYPASS(1), .ZERO_R0(1)) u_z (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata[15:0]),
      .re(re[1:0]), .raddr(raddr[5:0]), .rdata(rd_z), .rvalid(rv_z), .q(q_z));
   reg_file_mr #(.WIDTH(16), .DEPTH(6), .NREAD(2), .BYPASS(1), .ZERO_R0(0)) u_d6 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata[15:0]),
      .re(re[1:0]), .raddr(raddr[5:0]), .rdata(rd_d6), .rvalid(rv_d6), .q(q_d6));
   reg_file_mr #(.WIDTH(32), .DEPTH(8), .NREAD(3), .BYPASS(1), .ZERO_R0(0)) u_n3 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rd_n3), .rvalid(rv_n3), .q(q_n3));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; re = '0; raddr = '0;

      // 1: reset, then every address reads zero
      step(); step();
      chk("rst_q", q_def, 0);
      chk("rst_rdata", rd_def, 0);
      chk("rst_rvalid", rv_def, 0);
      chk("rst_rvalid_n3", rv_n3, 0);
      rst = 1'b0;
      for (int a = 0; a < 8; a++) begin
         re = 3'b001; raddr = 9'(a);
         step();
         chk("rd0_zero", rd_def[15:0], 0);
         chk("rd0_valid", rv_def, 2'b01);
      end

      // 2: walking writes of FFFF, read back on both ports
      exp_q = '0;
      for (int k = 0; k < 8; k++) begin
         we = 1'b1; waddr = 3'(k); wdata = 32'h0000FFFF; re = '0;
         step();
         exp_q[k*16 +: 16] = 16'hFFFF;
         chk("walk_q", q_def, exp_q);
         chk("walk_rvalid_idle", rv_def, 0);
         we = 1'b0; re = 3'b011; raddr = {3'd0, 3'(k), 3'(k)};
         step();
         chk("walk_rd", rd_def, 32'hFFFF_FFFF);
         chk("walk_rv", rv_def, 2'b11);
      end
      chk("walk_q_full", q_def, {128{1'b1}});

      // 3: same-cycle write/read of reg3 with and without bypass
      we = 1'b1; waddr = 3'd3; wdata = 32'h00001234; re = '0;
      step();
      we = 1'b1; waddr = 3'd3; wdata = 32'h0000A5A5; re = 3'b001; raddr = 9'd3;
      step();
      chk("byp_on", rd_def[15:0], 16'hA5A5);
      chk("byp_off", rd_nb[15:0], 16'h1234);
      chk("byp_off_port1_hold", rd_nb[31:16], 16'hFFFF);
      chk("byp_off_rv", rv_nb, 2'b01);
      we = 1'b0;
      step();
      chk("b2b_off", rd_nb[15:0], 16'hA5A5);
      chk("b2b_on", rd_def[15:0], 16'hA5A5);

      // 4: register 0 pinned to zero
      we = 1'b1; waddr = 3'd0; wdata = 32'h0000BEEF; re = 3'b001; raddr = 9'd0;
      step();
      chk("z_byp_r0", rd_z[15:0], 0);
      chk("z_rv", rv_z, 2'b01);
      chk("z_q0", q_z[15:0], 0);
      chk("def_q0", q_def[15:0], 16'hBEEF);
      we = 1'b1; waddr = 3'd1; wdata = 32'h0000BEEF; re = 3'b001; raddr = 9'd0;
      step();
      chk("z_rd_r0", rd_z[15:0], 0);
      we = 1'b0; re = 3'b001; raddr = 9'd1;
      step();
      chk("z_rd_r1", rd_z[15:0], 16'hBEEF);
      chk("z_q1", q_z[31:16], 16'hBEEF);

      // 5: DEPTH=6, out-of-range write and reads
      we = 1'b1; waddr = 3'd7; wdata = 32'h00005555; re = 3'b011; raddr = {3'd0, 3'd7, 3'd6};
      step();
      chk("d6_q", q_d6, {16'hFFFF, 16'hFFFF, 16'hA5A5, 16'hFFFF, 16'hBEEF, 16'hBEEF});
      chk("d6_rd_oor", rd_d6, 0);
      chk("d6_rv_oor", rv_d6, 2'b11);
      we = 1'b0; re = 3'b001; raddr = 9'd3;
      step();
      chk("d6_rd3", rd_d6[15:0], 16'hA5A5);

      // 6: three 32-bit ports, selective enables, reset mid-stream
      we = 1'b1; waddr = 3'd2; wdata = 32'hDEADBEEF; re = '0;
      step();
      waddr = 3'd5; wdata = 32'h12345678;
      step();
      we = 1'b0; re = 3'b010; raddr = {3'd0, 3'd7, 3'd0};
      step();
      chk("n3_p1_seed", rd_n3[63:32], 32'h00005555);
      chk("n3_rv_seed", rv_n3, 3'b010);
      re = 3'b101; raddr = {3'd5, 3'd2, 3'd2};
      step();
      chk("n3_p0", rd_n3[31:0], 32'hDEADBEEF);
      chk("n3_p1_hold", rd_n3[63:32], 32'h00005555);
      chk("n3_p2", rd_n3[95:64], 32'h12345678);
      chk("n3_rv", rv_n3, 3'b101);
      rst = 1'b1; re = 3'b111; we = 1'b1; waddr = 3'd4; wdata = 32'hCAFEF00D;
      step();
      chk("n3_rst_rv", rv_n3, 0);
      chk("n3_rst_rd", rd_n3, 0);
      chk("n3_rst_q", q_n3, 0);
      rst = 1'b0; re = '0; we = 1'b0;
      step();
      chk("n3_post_rst_rv", rv_n3, 0);
      chk("def_post_rst_q", q_def, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/reg_file_mr.md
Name: reg_file_mr

Overview:
- Parametrised multi-read-port register file with registered read outputs and optional write-to-read bypass.
- Successor to the combinational 8:1 x 16-bit register select path in the memory stage.
- Sits between the writeback stage and the operand-fetch stage of the processor.
- Also exposes the full flattened register contents as a Q bus for debug and legacy select logic.

Parameters:
- WIDTH, 16, bits per register.
- DEPTH, 8, number of registers; any value >= 2, not required to be a power of 2.
- NREAD, 2, number of independent read ports.
- BYPASS, 1, 1 = read of the address being written in the same cycle returns the new wdata; 0 = returns the old contents.
- ZERO_R0, 0, 1 = register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  AW  write address; AW = clog2(DEPTH).
- wdata  in  WIDTH  write data.
- re  in  NREAD  per-port read enable.
- raddr  in  NREAD*AW  flattened read addresses; port i occupies bits [i*AW +: AW].
- rdata  out  NREAD*WIDTH  flattened registered read data; port i occupies bits [i*WIDTH +: WIDTH].
- rvalid  out  NREAD  per-port valid, asserted one cycle after re.
- q  out  DEPTH*WIDTH  all registers; register k occupies bits [k*WIDTH +: WIDTH], same ordering as the legacy Q bus.

Behaviour:
- Reset: when rst=1 at a rising edge, all registers, rdata and rvalid clear to 0. rst has priority over we and re in that cycle.
- Write: when we=1 and waddr < DEPTH, reg[waddr] <= wdata at the edge.
  - waddr >= DEPTH is silently ignored and no register changes.
  - With ZERO_R0=1, writes to address 0 are ignored.
- Read latency is 1 cycle.
  - When re[i]=1 at edge N, rdata port i holds the read result and rvalid[i]=1 after edge N.
  - When re[i]=0, rdata port i holds its previous value and rvalid[i]=0.
- Read result:
  - raddr >= DEPTH returns 0.
  - ZERO_R0=1 and raddr=0 returns 0.
  - If BYPASS=1, we=1 and raddr==waddr (address valid and writable), returns wdata.
  - Otherwise returns the pre-edge reg[raddr].
- Multiple ports may read the same address in the same cycle; each port returns the identical value.
- q is combinational from the register array and reflects writes after the edge.
  - With ZERO_R0=1, the slice for register 0 is forced to 0.
- Back-to-back: a write at edge N followed by a read of the same address at edge N+1 returns the new data for either BYPASS value.
- Reset mid-stream: any read issued in the reset cycle is dropped, with rvalid=0 on the following cycle.
- No X propagation: every output is defined from the first edge after reset.

Decomposition:
- Shared package/include holds:
  - the AW computation (clog2 function);
  - default WIDTH/DEPTH constants shared with the ALU and decoder;
  - a slice helper macro for flattened-bus indexing.
- One sub-module, rf_read_port, instantiated NREAD times via generate. It contains:
  - address range check;
  - ZERO_R0 masking;
  - bypass compare;
  - rdata/rvalid registers.
- The register array and write logic live in the top module.

Test Plan:
1. Reset with default parameters: rst=1 for 2 cycles -> q=0, rdata=0, rvalid=0; then read all 8 addresses -> every read returns 16'h0000.
2. Write walking pattern: write 16'hFFFF to address k, read it next cycle on port 0 and port 1 -> the addressed port returns 16'hFFFF. After k=7, q=128'hFFFF... in the corresponding slices, matching the legacy select expectations.
3. Bypass, BYPASS=1: we=1, waddr=3, wdata=16'hA5A5, raddr0=3 in the same cycle, with reg3 previously 16'h1234 -> rdata0=16'hA5A5. Rerun with BYPASS=0 -> rdata0=16'h1234, and a read next cycle returns 16'hA5A5.
4. ZERO_R0=1: write 16'hBEEF to address 0 -> read returns 0 and q[15:0]=0. Address 1 still writes and reads 16'hBEEF.
5. DEPTH=6 (non-power-of-2): write to address 7 -> no change to any register. Read of address 6 -> rdata=0 and rvalid=1.
6. NREAD=3, WIDTH=32: three ports read addresses 2, 2 and 5 simultaneously with re=3'b101 -> ports 0 and 2 are valid with the correct 32-bit data, and port 1 holds its previous value with rvalid[1]=0. Assert rst in the next cycle -> all rvalid=0 the following cycle.
